// File: rtl/serial_a_paralelo_sync.sv
// Serial-to-parallel receiver with comma-based byte alignment.
// Hunts for COM_SYM bit by bit, then needs SYNC_COUNT aligned commas before delivering bytes.
module serial_a_paralelo_sync #(
    parameter logic [7:0]  COM_SYM    = 8'hBC,
    parameter logic [7:0]  IDLE_SYM   = 8'h7C,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       data_in,
    output logic       active,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       idle_out
);

    typedef enum logic [1:0] {HUNT, SYNC, ACTIVE} state_t;

    localparam logic [4:0] SYNC_MAX = 5'(SYNC_COUNT);

    state_t     state, state_nx;
    logic [7:0] sr, sr_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [3:0] com_cnt, com_cnt_nx;
    logic [4:0] com_inc;
    logic       active_nx, valid_nx, idle_nx, byte_done;
    logic [7:0] data_nx;

    always_comb begin
        sr_nx      = {sr[6:0], data_in};
        byte_done  = (bit_cnt == 3'd7);
        com_inc    = {1'b0, com_cnt} + 5'd1;
        state_nx   = state;
        bit_cnt_nx = bit_cnt + 3'd1;
        com_cnt_nx = com_cnt;
        active_nx  = active;
        data_nx    = data_out;
        valid_nx   = 1'b0;
        idle_nx    = idle_out;
        case (state)
            HUNT: begin
                bit_cnt_nx = '0;
                if (sr_nx == COM_SYM) begin
                    state_nx   = SYNC;
                    com_cnt_nx = 4'd1;
                end
            end
            SYNC: begin
                if (byte_done) begin
                    if (sr_nx == COM_SYM) begin
                        // Saturate at SYNC_COUNT; reaching it switches to ACTIVE on the same edge
                        if (com_inc >= SYNC_MAX) begin
                            com_cnt_nx = SYNC_MAX[3:0];
                            state_nx   = ACTIVE;
                            active_nx  = 1'b1;
                        end else begin
                            com_cnt_nx = com_inc[3:0];
                        end
                    end else begin
                        state_nx   = HUNT;
                        com_cnt_nx = '0;
                        active_nx  = 1'b0;
                    end
                end
            end
            ACTIVE: begin
                if (byte_done) begin
                    data_nx  = sr_nx;
                    valid_nx = 1'b1;
                    idle_nx  = (sr_nx == IDLE_SYM);
                end
            end
            default: state_nx = HUNT;
        endcase
    end

    always_ff @(posedge clk32f) begin
        if (reset) begin
            state     <= HUNT;
            sr        <= '0;
            bit_cnt   <= '0;
            com_cnt   <= '0;
            active    <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
            idle_out  <= 1'b0;
        end else begin
            state     <= state_nx;
            sr        <= sr_nx;
            bit_cnt   <= bit_cnt_nx;
            com_cnt   <= com_cnt_nx;
            active    <= active_nx;
            data_out  <= data_nx;
            valid_out <= valid_nx;
            idle_out  <= idle_nx;
        end
    end

endmodule

// File: tb/tb_serial_a_paralelo_sync.sv
// Self-checking bench for serial_a_paralelo_sync: vector table, directed corner sequences,
// and randomized traffic checked every cycle against a bit-index based reference model.
module tb_serial_a_paralelo_sync;

    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] IDLE = 8'h7C;
    localparam int         NSYNC = 4;

    logic       clk32f = 1'b0;
    logic       reset = 1'b1;
    logic       data_in = 1'b0;
    logic       active, valid_out, idle_out;
    logic [7:0] data_out;

    int passed = 0;
    int total  = 0;

    serial_a_paralelo_sync #(.COM_SYM(COM), .IDLE_SYM(IDLE), .SYNC_COUNT(NSYNC)) dut (
        .clk32f(clk32f), .reset(reset), .data_in(data_in),
        .active(active), .data_out(data_out), .valid_out(valid_out), .idle_out(idle_out)
    );

    always #5 clk32f = ~clk32f;

    // Reference model: alignment tracked as the bit index where the comma was found;
    // a byte boundary is every multiple of 8 bits after that index.
    int         m_mode;   // 0 hunting, 1 syncing, 2 active
    int         m_n, m_anchor, m_ncom;
    logic [7:0] m_hist, m_data;
    logic       m_active, m_valid, m_idle;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic model(input logic r, input logic b);
        if (r) begin
            m_mode = 0; m_n = 0; m_anchor = 0; m_ncom = 0;
            m_hist = 8'h00; m_data = 8'h00;
            m_active = 0; m_valid = 0; m_idle = 0;
        end else begin
            m_n++;
            m_hist = 8'(((int'(m_hist) * 2) + int'(b)) % 256);
            m_valid = 0;
            case (m_mode)
                0: if (m_hist == COM) begin m_mode = 1; m_anchor = m_n; m_ncom = 1; end
                1: if ((m_n - m_anchor) % 8 == 0) begin
                       if (m_hist == COM) begin
                           m_ncom++;
                           if (m_ncom >= NSYNC) begin m_mode = 2; m_active = 1; end
                       end else begin
                           m_mode = 0; m_ncom = 0;
                       end
                   end
                default: if ((m_n - m_anchor) % 8 == 0) begin
                       m_data = m_hist; m_valid = 1; m_idle = (m_hist == IDLE);
                   end
            endcase
        end
    endtask

    task automatic step(input logic r, input logic b);
        reset = r;
        data_in = b;
        @(posedge clk32f);
        #1;
        model(r, b);
        chk("m_active", {7'd0, active}, {7'd0, m_active});
        chk("m_valid", {7'd0, valid_out}, {7'd0, m_valid});
        chk("m_data", data_out, m_data);
        chk("m_idle", {7'd0, idle_out}, {7'd0, m_idle});
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(1'b0, v[i]);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b1, 1'b0);
    endtask

    typedef struct {
        logic [7:0] byte_v;
        logic       exp_active;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_idle;
    } vec_t;

    vec_t tbl[7];
    logic [7:0] ser[20];
    logic       seen;

    initial begin
        tbl[0] = '{COM,   1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{COM,   1'b0, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{COM,   1'b0, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{COM,   1'b1, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{8'h7C, 1'b1, 1'b1, 8'h7C, 1'b1};
        tbl[5] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
        tbl[6] = '{COM,   1'b1, 1'b1, 8'hBC, 1'b0};

        // Reset state, then table: sync on 4 commas, deliver 7C/A5/BC
        do_reset(2);
        chk("reset_active", {7'd0, active}, 8'd0);
        chk("reset_data", data_out, 8'h00);
        chk("reset_valid", {7'd0, valid_out}, 8'd0);
        chk("reset_idle", {7'd0, idle_out}, 8'd0);
        for (int i = 0; i < 7; i++) begin
            send_byte(tbl[i].byte_v);
            chk($sformatf("tbl%0d_active", i), {7'd0, active}, {7'd0, tbl[i].exp_active});
            chk($sformatf("tbl%0d_valid", i), {7'd0, valid_out}, {7'd0, tbl[i].exp_valid});
            chk($sformatf("tbl%0d_data", i), data_out, tbl[i].exp_data);
            chk($sformatf("tbl%0d_idle", i), {7'd0, idle_out}, {7'd0, tbl[i].exp_idle});
        end
        step(1'b0, 1'b0);
        chk("valid_one_cycle", {7'd0, valid_out}, 8'd0);
        chk("data_hold", data_out, 8'hBC);

        // Three stray bits then commas: active after bit 35, IDLE after bit 43
        do_reset(2);
        step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(COM);
        chk("offset_active", {7'd0, active}, 8'd1);
        send_byte(IDLE);
        chk("offset_data", data_out, IDLE);
        chk("offset_valid", {7'd0, valid_out}, 8'd1);
        chk("offset_idle", {7'd0, idle_out}, 8'd1);

        // Broken comma run: never reaches active
        do_reset(2);
        send_byte(COM); send_byte(COM); send_byte(8'h55); send_byte(COM); send_byte(COM);
        chk("broken_run_active", {7'd0, active}, 8'd0);
        chk("broken_run_valid", {7'd0, valid_out}, 8'd0);

        // Reset mid-byte while active, then fresh resync
        do_reset(1);
        for (int i = 0; i < 4; i++) send_byte(COM);
        step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk("midreset_active", {7'd0, active}, 8'd0);
        chk("midreset_data", data_out, 8'h00);
        for (int i = 0; i < 3; i++) send_byte(COM);
        chk("resync_not_yet", {7'd0, active}, 8'd0);
        send_byte(COM);
        chk("resync_active", {7'd0, active}, 8'd1);

        // Reset coincident with the last bit of a byte wins
        for (int i = 7; i >= 1; i--) step(1'b0, 1'(8'hA5 >> i));
        step(1'b1, 1'b1);
        chk("reset_wins_valid", {7'd0, valid_out}, 8'd0);
        chk("reset_wins_data", data_out, 8'h00);

        // Reset coincident with the completing comma blocks activation
        for (int i = 0; i < 3; i++) send_byte(COM);
        for (int i = 7; i >= 1; i--) step(1'b0, COM[i]);
        step(1'b1, COM[0]);
        chk("reset_blocks_sync", {7'd0, active}, 8'd0);

        // Looped IDLE serializer: commas first, then IDLE/COM alternation
        do_reset(2);
        for (int i = 0; i < 20; i++) ser[i] = (i < 4 || i % 2 == 1) ? COM : IDLE;
        seen = 1'b0;
        for (int i = 0; i < 160; i++) begin
            step(1'b0, ser[i / 8][7 - (i % 8)]);
            if (i < 40 && active) seen = 1'b1;
            if (valid_out) chk("loop_symbol", {7'd0, (data_out == COM || data_out == IDLE)}, 8'd1);
        end
        chk("loop_active_40", {7'd0, seen}, 8'd1);

        // Randomized traffic against the model
        do_reset(2);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: send_byte(COM);
                4, 5: send_byte(IDLE);
                6: send_byte(8'($urandom));
                7: do_reset(1);
                default: step(1'b0, 1'($urandom));
            endcase
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/serial_a_paralelo_sync.md
SERIAL_A_PARALELO_SYNC -- requirements
Module: serial_a_paralelo_sync

Interface
REQ-001 Parameter COM_SYM, default 8'hBC: comma symbol used for byte alignment.
REQ-002 Parameter IDLE_SYM, default 8'h7C: IDLE symbol flagged on idle_out.
REQ-003 Parameter SYNC_COUNT, default 4: number of consecutive aligned COM_SYM bytes needed to declare sync (legal range 2..15).
REQ-004 clk32f  input  1  bit clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 data_in  input  1  serial bit stream, MSB of each byte first, one bit per clk32f.
REQ-007 active  output  1  high while the link is byte-aligned and synced.
REQ-008 data_out  output  8  last completed byte while active.
REQ-009 valid_out  output  1  one-cycle strobe: data_out updated.
REQ-010 idle_out  output  1  high while data_out equals IDLE_SYM.

Function
REQ-011 The block SHALL keep an 8-bit shift register sr, updated every edge as sr <= {sr[6:0], data_in}; "new sr" means the value after that edge.
REQ-012 The block SHALL implement states HUNT, SYNC and ACTIVE.
REQ-013 HUNT: every edge, if new sr == COM_SYM, the block SHALL go to SYNC with bit_cnt = 0 and com_cnt = 1; otherwise it stays in HUNT (bit-level sliding search, no fixed alignment).
REQ-014 In SYNC and ACTIVE, bit_cnt (3 bits) SHALL increment every edge; a byte completes on the edge where bit_cnt wraps 7 -> 0, and that byte is new sr.
REQ-015 SYNC, byte complete == COM_SYM: com_cnt SHALL increment; on reaching SYNC_COUNT, the state SHALL become ACTIVE and active SHALL be 1 after that same edge.
REQ-016 SYNC, byte complete != COM_SYM: the state SHALL return to HUNT with com_cnt = 0 and active = 0; that byte SHALL NOT be re-examined for COM at a shifted position except through the normal HUNT search of subsequent edges.
REQ-017 ACTIVE, every byte complete: data_out SHALL load the byte, valid_out SHALL be 1 for exactly the following cycle, and idle_out SHALL be set to (byte == IDLE_SYM); COM bytes are also delivered.
REQ-018 Between byte completions, data_out and idle_out SHALL hold and valid_out SHALL be 0.
REQ-019 ACTIVE SHALL persist until reset; no bytes are delivered and valid_out stays 0 in HUNT and SYNC.
REQ-020 Latency: the edge sampling the last bit of a byte SHALL be the edge that updates data_out, valid_out and idle_out (zero extra pipeline stages).
REQ-021 com_cnt SHALL saturate at SYNC_COUNT; it is not used in ACTIVE.

Reset
REQ-022 While reset is high at an edge, sr, bit_cnt, com_cnt SHALL be 0, state HUNT, active = 0, data_out = 8'h00, valid_out = 0, idle_out = 0.
REQ-023 Reset SHALL override all other events at the same edge, including a byte completion or reaching SYNC_COUNT.
REQ-024 Reset asserted mid-ACTIVE SHALL clear active at that edge; re-sync SHALL require SYNC_COUNT fresh COM_SYM bytes.
REQ-025 After reset release, a COM_SYM SHALL be detectable as soon as its 8 bits have been shifted in (reset-zeroed sr never matches 8'hBC).

Verification
REQ-026 Reset 2 cycles, then 4 x 8'hBC back to back -> active rises after edge of bit 32; valid_out stays 0 throughout.
REQ-027 Reset, 3 bits 1,0,1, then 4 x 8'hBC, then 8'h7C -> active after bit 35; after bit 43 data_out = 8'h7C, valid_out one-cycle pulse, idle_out = 1.
REQ-028 Reset, 8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC -> return to HUNT at bit 24, re-enter SYNC at bit 32, com_cnt = 2 after bit 40, active never asserts.
REQ-029 ACTIVE, send 8'h7C, 8'hA5, 8'hBC -> data_out 7C/A5/BC with valid_out pulsed every 8 cycles; idle_out 1, 0, 0.
REQ-030 ACTIVE, assert reset one cycle at bit 4 of a byte -> all outputs 0 next cycle; then 4 x 8'hBC -> active again after 32 bits.
REQ-031 Upstream IDLE serializer output looped to data_in -> active asserts within 40 cycles of both leaving reset and data_out alternates only between COM_SYM and IDLE_SYM values it emits.
